riscv_muldiv: RTL and testbench

RISCV_MULDIV -- requirements
Module: riscv_muldiv

---
 rtl/riscv_m_pkg.sv | 44 ++++
 rtl/muldiv_step.sv | 37 +++
 rtl/riscv_muldiv.sv | 225 ++++++++++++++++++++++
 tb/tb_riscv_muldiv.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide unit:
// funct3 operation encodings, FSM states and decoder constants.
package riscv_m_pkg;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  // R-type OP opcode and funct7 value that select the M extension
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Divide/remainder group occupies funct3[2] = 1
  function automatic logic is_div_op(input muldiv_op_e op);
    return op[2];
  endfunction

  // rs1 is interpreted as signed for MULH, MULHSU, DIV and REM
  function automatic logic rs1_is_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is interpreted as signed for MULH, DIV and REM
  function automatic logic rs2_is_signed(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath, purely combinational.
// Multiply: shift-add, {hi,lo} holds the partial product with the multiplier
// consumed from lo[0]. Divide: restoring, hi is the partial remainder and lo
// shifts the dividend out at the top while quotient bits enter at the bottom.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div_i,
  input  logic [XLEN-1:0] opnd_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Single shift-add or trial-subtract step
  always_comb begin
    add_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
    shifted = {hi_i, lo_i[XLEN-1]};
    ge      = (shifted >= {1'b0, opnd_i});
    // When ge holds the true difference is below the divisor, so XLEN bits suffice
    diff    = shifted[XLEN-1:0] - opnd_i;
    if (is_div_i) begin
      hi_o = ge ? diff : shifted[XLEN-1:0];
      lo_o = {lo_i[XLEN-2:0], ge};
    end else begin
      hi_o = add_sum[XLEN:1];
      lo_o = {add_sum[0], lo_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RISC-V M-extension unit. Operands are converted to magnitudes on
// accept, CALC retires UNROLL bits per cycle, FIX applies result signs, and
// DONE presents the result until the consumer takes it. Divide-by-zero and
// signed overflow skip straight to DONE.
module riscv_muldiv
  import riscv_m_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int NSTEPS = XLEN / UNROLL;
  localparam int CW     = $clog2(NSTEPS);
  localparam logic [CW-1:0]   LAST_STEP = CW'(NSTEPS - 1);
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  // Illegal parameterisations stop elaboration
  generate
    if (!((XLEN == 32) || (XLEN == 64))) begin : g_bad_xlen
      $fatal(1, "riscv_muldiv: XLEN must be 32 or 64");
    end
    if (!((UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4)) || ((XLEN % UNROLL) != 0)) begin : g_bad_unroll
      $fatal(1, "riscv_muldiv: UNROLL must be 1, 2 or 4 and divide XLEN");
    end
  endgenerate

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            sign1_q, sign1_d;
  logic            sign2_q, sign2_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Request decode
  muldiv_op_e      in_op_e;
  logic            in_is_div;
  logic            in_s1, in_s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_by_zero, div_overflow, in_special;
  logic [XLEN-1:0] special_res;
  logic            accept;

  assign in_op_e      = muldiv_op_e'(in_op);
  assign in_is_div    = is_div_op(in_op_e);
  assign in_s1        = rs1_is_signed(in_op_e) & in_rs1[XLEN-1];
  assign in_s2        = rs2_is_signed(in_op_e) & in_rs2[XLEN-1];
  assign mag1         = in_s1 ? -in_rs1 : in_rs1;
  assign mag2         = in_s2 ? -in_rs2 : in_rs2;
  assign div_by_zero  = in_is_div && (in_rs2 == '0);
  assign div_overflow = ((in_op_e == OP_DIV) || (in_op_e == OP_REM)) &&
                        (in_rs1 == MOST_NEG) && (in_rs2 == '1);
  assign in_special   = div_by_zero || div_overflow;
  // funct3[1] separates the remainder ops from the quotient ops
  assign special_res  = div_by_zero ? (in_op[1] ? in_rs1 : '1)
                                    : (in_op[1] ? '0 : in_rs1);
  assign accept       = in_valid && (state_q == ST_IDLE) && !flush;

  // Iteration chain: UNROLL steps per CALC cycle
  logic [XLEN-1:0] hi_chain [UNROLL+1];
  logic [XLEN-1:0] lo_chain [UNROLL+1];

  assign hi_chain[0] = hi_q;
  assign lo_chain[0] = lo_q;

  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div_i (is_div_op(op_q)),
        .opnd_i   (opnd_q),
        .hi_i     (hi_chain[gi]),
        .lo_i     (lo_chain[gi]),
        .hi_o     (hi_chain[gi+1]),
        .lo_o     (lo_chain[gi+1])
      );
    end
  endgenerate

  // Sign fix-up of the magnitude result
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // Negate the product/quotient/remainder according to the captured signs
  always_comb begin
    prod_raw = {hi_q, lo_q};
    prod_fix = (sign1_q ^ sign2_q) ? -prod_raw : prod_raw;
    quo_fix  = (sign1_q ^ sign2_q) ? -lo_q : lo_q;
    rem_fix  = sign1_q ? -hi_q : hi_q;
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = quo_fix;
      default:                      fix_res = rem_fix;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    busy       = 1'b1;
    out_valid  = 1'b0;
    out_result = '0;
    out_rd     = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept) begin
          state_d = in_special ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt_q == LAST_STEP) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_DONE;
      end
      default: begin
        out_valid  = 1'b1;
        out_result = res_q;
        out_rd     = rd_q;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    // Abort wins over every other transition outside IDLE
    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Datapath next-state: capture on accept, iterate in CALC, fix up in FIX
  always_comb begin
    op_d    = op_q;
    rd_d    = rd_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = in_op_e;
          rd_d    = in_rd;
          sign1_d = in_s1;
          sign2_d = in_s2;
          hi_d    = '0;
          cnt_d   = '0;
          lo_d    = in_is_div ? mag1 : mag2;
          opnd_d  = in_is_div ? mag2 : mag1;
          res_d   = special_res;
        end
      end
      ST_CALC: begin
        hi_d  = hi_chain[UNROLL];
        lo_d  = lo_chain[UNROLL];
        cnt_d = cnt_q + CW'(1);
      end
      ST_FIX: begin
        res_d = fix_res;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_MUL;
      rd_q    <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      op_q    <= op_d;
      rd_q    <= rd_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed scoreboard bench for riscv_muldiv (XLEN=32, UNROLL=1).
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        busy;

  localparam int NORM_LAT = 34;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  riscv_muldiv #(.XLEN(32), .UNROLL(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a single edge and push its expected outcome
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] expres, input int lat);
    exp_t e;
    e.res = expres;
    e.rd  = rd;
    e.lat = lat;
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = a;
    in_rs2   = b;
    in_rd    = rd;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    in_rs1   = $urandom;
    in_rs2   = $urandom;
    in_rd    = 5'($urandom);
    check({tag, "_busy"}, busy, 1);
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall, then take it
  task automatic collect(input string tag, input int stall);
    int cyc;
    exp_t e;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    e = sb.pop_front();
    $display("txn %s: result=0x%08h rd=%0d latency=%0d", tag, out_result, out_rd, cyc);
    check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    check({tag, "_result"}, out_result, e.res);
    check({tag, "_rd"}, out_rd, e.rd);
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_result"}, out_result, e.res);
      check({tag, "_stall_rd"}, out_rd, e.rd);
      check({tag, "_stall_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, out_valid, 0);
    check({tag, "_post_result"}, out_result, 0);
    check({tag, "_post_in_ready"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd,
                     input logic [31:0] expres, input int lat, input int stall);
    issue(tag, op, a, b, rd, expres, lat);
    collect(tag, stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    logic        seen;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_rd     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_result", out_result, 0);
    check("reset_out_rd", out_rd, 0);
    rst = 1'b0;
    tick();

    // Multiply group
    run("mul_7_m3",   3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, NORM_LAT, 0);
    run("mulhu_m1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, NORM_LAT, 0);
    run("mulh_m1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0000_0000, NORM_LAT, 0);
    run("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, NORM_LAT, 0);
    run("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 5'd12, 32'h4000_0000, NORM_LAT, 0);
    p = 64'(32'h1234_5678) * 64'(32'h9ABC_DEF0);
    run("mul_big",    3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd13, p[31:0], NORM_LAT, 5);
    run("mulhu_big",  3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, p[63:32], NORM_LAT, 0);

    // Divide group
    run("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, NORM_LAT, 0);
    run("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, NORM_LAT, 0);
    run("div_20_m3",  3'd4, 32'd20, 32'hFFFF_FFFD, 5'd15, 32'hFFFF_FFFA, NORM_LAT, 0);
    run("rem_20_m3",  3'd6, 32'd20, 32'hFFFF_FFFD, 5'd16, 32'd2, NORM_LAT, 0);
    run("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd17, 32'(100 / 7), NORM_LAT, 0);
    run("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd18, 32'(100 % 7), NORM_LAT, 0);

    // Special cases with single-cycle latency
    run("divu_by0",   3'd5, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 1, 0);
    run("rem_by0",    3'd6, 32'hFFFF_FFF9, 32'd0, 5'd8, 32'hFFFF_FFF9, 1, 0);
    run("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1, 0);
    run("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h0000_0000, 1, 2);

    // Flush in CALC cycle 10: no result ever appears
    in_valid = 1'b1;
    in_op    = 3'd0;
    in_rs1   = 32'h0000_1234;
    in_rs2   = 32'd5;
    in_rd    = 5'd20;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_busy", busy, 0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      seen = seen | out_valid;
    end
    check("flush_no_result", seen, 0);
    run("mul_3_4", 3'd0, 32'd3, 32'd4, 5'd11, 32'd12, NORM_LAT, 0);

    // Flush in IDLE blocks the accept
    in_valid = 1'b1;
    in_op    = 3'd5;
    in_rs1   = 32'd9;
    in_rs2   = 32'd0;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("idle_flush_busy", busy, 0);
    check("idle_flush_in_ready", in_ready, 1);
    check("idle_flush_out_valid", out_valid, 0);

    // Asynchronous reset in the middle of CALC
    in_valid = 1'b1;
    in_op    = 3'd4;
    in_rs1   = 32'd77;
    in_rs2   = 32'd3;
    in_rd    = 5'd21;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("rst_pre_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_in_ready", in_ready, 1);
    check("rst_async_busy", busy, 0);
    check("rst_async_out_valid", out_valid, 0);
    check("rst_async_out_result", out_result, 0);
    check("rst_async_out_rd", out_rd, 0);
    tick();
    rst = 1'b0;
    tick();
    run("divu_after_rst", 3'd5, 32'd1000, 32'd33, 5'd22, 32'(1000 / 33), NORM_LAT, 0);
    run("remu_after_rst", 3'd7, 32'd1000, 32'd33, 5'd23, 32'(1000 % 33), NORM_LAT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
